// File: rtl/pp_accumulator_if.sv
// rtl/pp_accumulator_if.sv - partial-product row stream and product result bundle
interface pp_accumulator_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   pp_in;
    logic               pp_valid;
    logic               pp_ready;
    logic [2*WIDTH-1:0] prod;
    logic               prod_valid;
    logic               busy;

    modport master (
        output pp_in, pp_valid,
        input  pp_ready, prod, prod_valid, busy
    );

    modport slave (
        input  pp_in, pp_valid,
        output pp_ready, prod, prod_valid, busy
    );
endinterface

// File: rtl/pp_accumulator.sv
// rtl/pp_accumulator.sv - shift-add accumulator for partial-product rows with optional low-column truncation
module pp_accumulator #(
    parameter int WIDTH = 16,
    parameter int TRUNC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    pp_accumulator_if.slave  pp
);
    localparam int RW = $clog2(WIDTH);
    localparam logic [RW-1:0]      LAST_ROW = RW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] MASK     = {(2*WIDTH){1'b1}} << TRUNC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [RW-1:0]      row;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] term;
    logic               accept;
    logic               publish;

    assign accept  = pp.pp_valid && pp.pp_ready && !clr;
    assign term    = ({{WIDTH{1'b0}}, pp.pp_in} << row) & MASK;
    // The finished sum is visible in the DONE cycle itself so prod and its pulse coincide.
    assign publish = (state == DONE) && !clr;

    assign pp.pp_ready   = (state != DONE);
    assign pp.busy       = (state == ACCUM);
    assign pp.prod_valid = publish;
    assign pp.prod       = publish ? acc : prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = ACCUM;
                ACCUM:   if (accept && row == LAST_ROW) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            row    <= '0;
            prod_q <= '0;
        end else if (clr) begin
            acc <= '0;
            row <= '0;
        end else if (state == DONE) begin
            prod_q <= acc;
            acc    <= '0;
            row    <= '0;
        end else if (accept) begin
            acc <= acc + term;
            row <= row + RW'(1);
        end
    end
endmodule
